// File: rtl/sram_ctl_pkg.sv
// Shared types and constants for the burst SRAM controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, read/write direction encodings and the
// width of the wait-state counter.
package sram_ctl_pkg;

  // One beat walks IDLE -> SETUP -> ACCESS (W+1 cycles) -> END.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wait states per beat are 0..15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state timer: counts the ACCESS phase of one SRAM beat.
// Latency: loads during SETUP, flags the last ACCESS cycle combinationally.
// Backpressure: none; follows the controller FSM.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        high while the FSM is in SETUP; counter takes wait_cyc
//   run         high while the FSM is in ACCESS; counter steps down
//   wait_cyc    extra ACCESS cycles for this beat (W)
//   last        high in the final ACCESS cycle (counter exhausted)
module sram_wait_timer
  import sram_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              run,
  input  logic [WAIT_W-1:0] wait_cyc,
  output logic              last
);

  logic [WAIT_W-1:0] cnt;

  // Loading W and counting to zero gives exactly W+1 ACCESS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= wait_cyc;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign last = run && (cnt == '0);

endmodule

// File: rtl/sram_burst_ctl.sv
// Async-SRAM controller with wait states, byte-masked writes and bursts.
// Latency: W+3 cycles per beat; a single read returns data W+3 cycles after start.
// Backpressure: none; start_i is only accepted in IDLE, ignored while busy_o=1.
//
// Optional feature macro: SRAM_CTL_WAIT_CFG_EN adds cfg_wait_i[3:0], whose
// value is latched with each request as the wait-state count (WAIT_CYC is
// then unused). Without the macro W is the WAIT_CYC parameter.
//
// Ports:
//   clk_i, rst_i                clock, async active-low reset
//   start_i, rw_i, addr_i,      request strobe, direction (1=read), first word
//   burst_len_i                 address and beats-1
//   data_i, data_be_i           write data / active-low byte enables per beat
//   data_req_o                  next write beat must be presented this cycle
//   data_o, r_valid_o           read data and its per-beat strobe
//   done_o, busy_o              last-cycle pulse, request-in-progress flag
//   sram_*                      external SRAM pins (active-low strobes)
module sram_burst_ctl
  import sram_ctl_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 20,
  parameter  int MAX_BURST = 8,
  parameter  int WAIT_CYC  = 1,
  localparam int BE_W      = DATA_W / 8,
  localparam int BL_W      = $clog2(MAX_BURST)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              rw_i,
`ifdef SRAM_CTL_WAIT_CFG_EN
  input  logic [3:0]        cfg_wait_i,
`endif
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BL_W-1:0]   burst_len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   data_be_i,
  output logic              data_req_o,
  output logic [DATA_W-1:0] data_o,
  output logic              r_valid_o,
  output logic              done_o,
  output logic              busy_o,
  inout  wire  [DATA_W-1:0] sram_data_io,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [BE_W-1:0]   sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  state_t            state;
  logic              rw;          // direction of the request in flight
  logic [BL_W-1:0]   beats_left;  // beats still to run after the current one
  logic [DATA_W-1:0] wdata;       // write data for the current beat
  logic              drive;       // controller owns the data bus
  logic [WAIT_W-1:0] wait_lat;    // W for the request in flight
  logic              access_last;

  // Wait-state source: run-time register or fixed parameter.
`ifdef SRAM_CTL_WAIT_CFG_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_lat <= '0;
    end else if ((state == IDLE) && start_i) begin
      wait_lat <= cfg_wait_i;
    end
  end
`else
  assign wait_lat = WAIT_W'(WAIT_CYC);
`endif

  sram_wait_timer u_wait_timer (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (state == SETUP),
    .run      (state == ACCESS),
    .wait_cyc (wait_lat),
    .last     (access_last)
  );

  // The bus is only driven by write requests, and only between request
  // acceptance and the return to IDLE, so it is never driven while oe_n=0.
  assign sram_data_io = drive ? wdata : 'z;

  // All SRAM pins and status outputs are registered and updated on the
  // transition into the state they belong to.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      rw          <= RW_READ;
      beats_left  <= '0;
      wdata       <= '0;
      drive       <= 1'b0;
      sram_addr_o <= '0;
      sram_be_n_o <= '1;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      data_o      <= '0;
      r_valid_o   <= 1'b0;
      done_o      <= 1'b0;
      data_req_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      r_valid_o  <= 1'b0;
      done_o     <= 1'b0;
      data_req_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= SETUP;
            rw          <= rw_i;
            beats_left  <= burst_len_i;
            sram_addr_o <= addr_i;
            sram_ce_n_o <= 1'b0;
            busy_o      <= 1'b1;
            if (rw_i == RW_WRITE) begin
              wdata       <= data_i;
              sram_be_n_o <= data_be_i;
              drive       <= 1'b1;
            end else begin
              // Reads always fetch the whole word.
              sram_be_n_o <= '0;
            end
          end
        end

        SETUP: begin
          state <= ACCESS;
          if (rw == RW_READ) begin
            sram_oe_n_o <= 1'b0;
          end else begin
            sram_we_n_o <= 1'b0;
          end
        end

        ACCESS: begin
          if (access_last) begin
            state       <= END;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            if (rw == RW_READ) begin
              // Sampled on the edge that closes the output-enable window.
              data_o    <= sram_data_io;
              r_valid_o <= 1'b1;
            end
            if (beats_left != '0) begin
              data_req_o <= (rw == RW_WRITE);
            end else begin
              done_o <= 1'b1;
            end
          end
        end

        END: begin
          // Address and write data stay put through END for hold time.
          if (beats_left != '0) begin
            state       <= SETUP;
            beats_left  <= beats_left - BL_W'(1);
            sram_addr_o <= sram_addr_o + ADDR_W'(1);
            if (rw == RW_WRITE) begin
              wdata       <= data_i;
              sram_be_n_o <= data_be_i;
            end
          end else begin
            state       <= IDLE;
            sram_ce_n_o <= 1'b1;
            sram_be_n_o <= '1;
            drive       <= 1'b0;
            busy_o      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_ctl.sv
// Bench for sram_burst_ctl: SRAM model on the shared bus plus a word-level
// reference memory that predicts read data, beat addresses and cycle counts.
// Idle/reset bus release is observed by the bench driving a probe pattern
// whenever the chip is deselected.
module tb_sram_burst_ctl;
  import sram_ctl_pkg::*;

  localparam logic [31:0] PROBE = 32'hA5C3_5A3C;
`ifdef SRAM_CTL_WAIT_CFG_EN
  localparam int W_DEF = 1;
`else
  localparam int WAIT_CYC = 1;
  localparam int W_DEF    = WAIT_CYC;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rw    = RW_READ;
  logic [19:0] addr  = '0;
  logic [2:0]  blen  = '0;
  logic [31:0] din   = '0;
  logic [3:0]  be    = '0;
`ifdef SRAM_CTL_WAIT_CFG_EN
  logic [3:0]  cfg_wait = '0;
`endif

  logic        data_req, r_valid, done, busy, ce_n, oe_n, we_n;
  logic [31:0] dout;
  logic [19:0] s_addr;
  logic [3:0]  s_be_n;
  wire  [31:0] s_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [int];   // contents of the external SRAM
  logic [31:0] ref_mem [int];   // what the controller should have written
  logic [31:0] rd_word = '0;
  logic [31:0] wd [8];
  logic [3:0]  wb [8];

  always #5 clk = ~clk;

  sram_burst_ctl dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .rw_i         (rw),
`ifdef SRAM_CTL_WAIT_CFG_EN
    .cfg_wait_i   (cfg_wait),
`endif
    .addr_i       (addr),
    .burst_len_i  (blen),
    .data_i       (din),
    .data_be_i    (be),
    .data_req_o   (data_req),
    .data_o       (dout),
    .r_valid_o    (r_valid),
    .done_o       (done),
    .busy_o       (busy),
    .sram_data_io (s_data),
    .sram_addr_o  (s_addr),
    .sram_be_n_o  (s_be_n),
    .sram_ce_n_o  (ce_n),
    .sram_oe_n_o  (oe_n),
    .sram_we_n_o  (we_n)
  );

  // SRAM side: output data while oe_n is low, probe pattern while deselected.
  assign s_data = (ce_n || !oe_n) ? (oe_n ? PROBE : rd_word) : 'z;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be_n);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (!be_n[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [31:0] cur;
    cur = mem.exists(int'(s_addr)) ? mem[int'(s_addr)] : 32'h0;
    if (!ce_n && !we_n) begin
      cur = merge(cur, s_data, s_be_n);
      mem[int'(s_addr)] = cur;
    end
    rd_word = cur;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      wb[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    end
  endtask

  function automatic int pick_w();
`ifdef SRAM_CTL_WAIT_CFG_EN
    return $urandom_range(0, 15);
`else
    return WAIT_CYC;
`endif
  endfunction

  // Issue one request and follow it to completion; junk (including start
  // pulses) is driven on all request inputs while the controller is busy.
  task automatic run_req(input logic r, input logic [19:0] a, input int len, input int w);
    int          beats;
    int          n, nreq, nrv, nwe, noe, nbusy, beat;
    bit          fin, acc, prev_acc;
    logic [19:0] ai;
    logic [31:0] exp_rd [8];

    beats = len + 1;
    for (int i = 0; i < beats; i++) begin
      ai = a + 20'(i);
      exp_rd[i] = ref_mem.exists(int'(ai)) ? ref_mem[int'(ai)] : 32'h0;
    end

    @(negedge clk);
    start = 1'b1; rw = r; addr = a; blen = 3'(len); din = wd[0]; be = wb[0];
`ifdef SRAM_CTL_WAIT_CFG_EN
    cfg_wait = 4'(w);
`endif
    @(negedge clk);
    n = 1; nreq = 0; nrv = 0; nwe = 0; noe = 0; nbusy = 0; beat = 0;
    fin = 1'b0; prev_acc = 1'b0;
    while (!fin && n <= 400) begin
      start = ($urandom_range(0, 3) == 0);
      rw    = 1'($urandom);
      addr  = 20'($urandom);
      blen  = 3'($urandom);
      din   = $urandom;
      be    = 4'($urandom);
`ifdef SRAM_CTL_WAIT_CFG_EN
      cfg_wait = 4'($urandom);
`endif
      if (busy) nbusy++;
      if (!we_n) nwe++;
      if (!oe_n) noe++;
      acc = !we_n || !oe_n;
      if (acc && !prev_acc) begin
        ai = a + 20'(beat);
        check("beat_addr", s_addr, ai);
        beat++;
      end
      prev_acc = acc;
      if (data_req) begin
        nreq++;
        if (nreq < 8) begin din = wd[nreq]; be = wb[nreq]; end
      end
      if (r_valid) begin
        if (nrv < 8) check("rdata", dout, exp_rd[nrv]);
        nrv++;
      end
      if (done) begin
        check("done_cycle", n, beats * (w + 3));
        if (r == RW_READ) check("rvalid_with_done", r_valid, 1);
        start = 1'b0;
        fin   = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;

    if (!fin) check("req_timeout", 0, 1);
    check("beats_seen", beat, beats);
    check("busy_cycles", nbusy, beats * (w + 3));
    if (r == RW_READ) begin
      check("oe_cycles", noe, beats * (w + 1));
      check("we_cycles", nwe, 0);
      check("rvalid_cnt", nrv, beats);
      check("req_cnt", nreq, 0);
    end else begin
      check("we_cycles", nwe, beats * (w + 1));
      check("oe_cycles", noe, 0);
      check("rvalid_cnt", nrv, 0);
      check("req_cnt", nreq, beats - 1);
      for (int i = 0; i < beats; i++) begin
        ai = a + 20'(i);
        ref_mem[int'(ai)] = merge(ref_mem.exists(int'(ai)) ? ref_mem[int'(ai)] : 32'h0,
                                  wd[i], wb[i]);
      end
    end

    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ce_n", ce_n, 1);
    check("idle_be_n", s_be_n, 4'hF);
    check("idle_bus_z", s_data, PROBE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        r;
    logic [19:0] a;

    // Reset held: toggling start must not wake anything up.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
      check("rst_be_n", s_be_n, 4'hF);
      check("rst_addr", s_addr, 20'h0);
      check("rst_busy", busy, 0);
      check("rst_pulses", {r_valid, done, data_req}, 3'b000);
      check("rst_dout", dout, 32'h0);
      check("rst_bus_z", s_data, PROBE);
      start = ~start;
      rw    = 1'($urandom);
      addr  = 20'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read back.
    wd[0] = 32'hDEADBEEF; wb[0] = 4'h0;
    run_req(RW_WRITE, 20'h00010, 0, W_DEF);
    run_req(RW_READ,  20'h00010, 0, W_DEF);
    check("t2_rdata", dout, 32'hDEADBEEF);

    // Byte-masked write over all-ones.
    wd[0] = 32'hFFFFFFFF; wb[0] = 4'h0;
    run_req(RW_WRITE, 20'h00020, 0, W_DEF);
    wd[0] = 32'h11223344; wb[0] = 4'b1100;
    run_req(RW_WRITE, 20'h00020, 0, W_DEF);
    run_req(RW_READ,  20'h00020, 0, W_DEF);
    check("t3_rdata", dout, 32'hFFFF3344);

    // Burst across the top of the address space.
    fill_rand();
    run_req(RW_WRITE, 20'hFFFFE, 3, W_DEF);
    run_req(RW_READ,  20'hFFFFE, 3, W_DEF);

`ifdef SRAM_CTL_WAIT_CFG_EN
    // Long run-time wait setting: 6 write-enable cycles, 8 busy cycles.
    fill_rand();
    run_req(RW_WRITE, 20'h00030, 0, 5);
    run_req(RW_READ,  20'h00030, 0, 5);
`endif

    // Reset in the middle of a burst, with a start attempt while busy.
    fill_rand();
    @(negedge clk);
    start = 1'b1; rw = RW_WRITE; addr = 20'h00040; blen = 3'd7; din = wd[0]; be = 4'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; rw = RW_READ; addr = 20'h00005;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_strobes", {ce_n, oe_n, we_n}, 3'b111);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_bus_z", s_data, PROBE);
    check("t5_be_n", s_be_n, 4'hF);
    @(negedge clk);
    check("t5_done_after", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic against the reference memory.
    for (int k = 0; k < 40; k++) begin
      fill_rand();
      r = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 31))
                                      : 20'hFFFF0 + 20'($urandom_range(0, 15));
      run_req(r, a, $urandom_range(0, 7), pick_w());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
